// File: rtl/hatch_seq_ctrl.sv
// Egg-hatch game sequencer: 1 s time base, BCD elapsed time, matrix frame index and
// heater-off watchdog. All outputs are registered and track the registered state.
module hatch_seq_ctrl #(
    parameter int TICK_DIV   = 1000,
    parameter int FRAME_SEC  = 2,
    parameter int GROW_FRAME = 10,
    parameter int DONE_FRAME = 16,
    parameter int COLD_LIMIT = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       start,
    input  logic       heat_on,
    output logic [2:0] state,
    output logic [4:0] frame,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       mx_en,
    output logic       disp_en,
    output logic       done,
    output logic       fail
);
    localparam int PW = $clog2(TICK_DIV);
    localparam int FW = (FRAME_SEC > 1) ? $clog2(FRAME_SEC) : 1;
    localparam int CW = $clog2(COLD_LIMIT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READY = 3'd1,
        S_HEAT  = 3'd2,
        S_GROW  = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [FW-1:0] fsec_q, fsec_d;
    logic [CW-1:0] cold_q, cold_d;
    logic [4:0]    frame_q, frame_d;
    logic [3:0]    tens_q, tens_d, ones_q, ones_d;
    logic          mx_en_q, mx_en_d, disp_en_q, disp_en_d;
    logic          done_q, done_d, fail_q, fail_d;
    logic          run, sec_tick;

    always_comb begin
        state_d  = state_q;
        presc_d  = presc_q;
        fsec_d   = fsec_q;
        cold_d   = cold_q;
        frame_d  = frame_q;
        tens_d   = tens_q;
        ones_d   = ones_q;
        run      = (state_q == S_HEAT) || (state_q == S_GROW);
        sec_tick = run && (presc_q == PW'(TICK_DIV - 1));

        case (state_q)
            S_IDLE:  state_d = S_READY;
            S_READY: if (start) state_d = S_HEAT;
            S_HEAT: begin
                if (frame_q == 5'(GROW_FRAME))      state_d = S_GROW;
                else if (cold_q == CW'(COLD_LIMIT)) state_d = S_FAIL;
            end
            S_GROW:  if (frame_q == 5'(DONE_FRAME)) state_d = S_DONE;
            S_DONE,
            S_FAIL:  if (start) state_d = S_READY;
            default: state_d = S_IDLE;
        endcase
        if (!enable) state_d = S_IDLE;

        // Prescaler only runs while hatching; DONE/FAIL freeze everything.
        if (run) presc_d = sec_tick ? '0 : presc_q + PW'(1);

        if (sec_tick && !(tens_q == 4'd9 && ones_q == 4'd9)) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                tens_d = tens_q + 4'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end

        if (sec_tick && ((state_q == S_HEAT && heat_on) || state_q == S_GROW)) begin
            if (fsec_q == FW'(FRAME_SEC - 1)) begin
                fsec_d = '0;
                if (frame_q < 5'(DONE_FRAME)) frame_d = frame_q + 5'd1;
            end else begin
                fsec_d = fsec_q + FW'(1);
            end
        end

        if (state_q != S_HEAT || heat_on) cold_d = '0;
        else if (sec_tick)                cold_d = cold_q + CW'(1);

        // IDLE and READY always hold a fresh game, so leaving them starts from zero.
        if (state_d == S_IDLE || state_d == S_READY) begin
            presc_d = '0;
            fsec_d  = '0;
            cold_d  = '0;
            frame_d = '0;
            tens_d  = '0;
            ones_d  = '0;
        end

        mx_en_d   = (state_d >= S_READY) && (state_d <= S_FAIL);
        disp_en_d = (state_d >= S_HEAT) && (state_d <= S_FAIL);
        done_d    = (state_d == S_DONE);
        fail_d    = (state_d == S_FAIL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            presc_q   <= '0;
            fsec_q    <= '0;
            cold_q    <= '0;
            frame_q   <= '0;
            tens_q    <= '0;
            ones_q    <= '0;
            mx_en_q   <= 1'b0;
            disp_en_q <= 1'b0;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            fsec_q    <= fsec_d;
            cold_q    <= cold_d;
            frame_q   <= frame_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            mx_en_q   <= mx_en_d;
            disp_en_q <= disp_en_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    assign state    = state_q;
    assign frame    = frame_q;
    assign sec_tens = tens_q;
    assign sec_ones = ones_q;
    assign mx_en    = mx_en_q;
    assign disp_en  = disp_en_q;
    assign done     = done_q;
    assign fail     = fail_q;
endmodule
